jtframe_cen_multi: RTL



---
 rtl/jtframe_cen_pkg.sv | 19 +
 rtl/jtframe_cen_ch.sv | 68 ++++++
 rtl/jtframe_cen_multi.sv | 68 ++++++
 3 files changed

// File: rtl/jtframe_cen_pkg.sv
// Shared defaults and packed-lane helper for the multi-channel fractional clock enable.
package jtframe_cen_pkg;

  localparam int CH_DEF     = 4;
  localparam int W_DEF      = 10;
  localparam int LOCK_DEF   = 30;
  localparam int LANE_MAXW  = 32;
  localparam int LANE_MAXCH = 16;
  localparam int LANE_VW    = LANE_MAXW * LANE_MAXCH;

  // Lane k of a vector packed as consecutive w-bit fields; upper result bits are zero.
  function automatic logic [LANE_MAXW-1:0] lane(input logic [LANE_VW-1:0] vec,
                                                 input int k, input int w = W_DEF);
    lane = LANE_MAXW'(vec >> (k * w));
    for (int i = 0; i < LANE_MAXW; i++)
      if (i >= w) lane[i] = 1'b0;
  endfunction

endpackage

// File: rtl/jtframe_cen_ch.sv
// One fractional clock-enable channel: n/m latch with change detect, accumulator,
// and half-rate companion enable.
module jtframe_cen_ch
  import jtframe_cen_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic [W-1:0] n,
  input  logic [W-1:0] m,
  output logic         chg,
  output logic         cen,
  output logic         cen2
);

  logic [W-1:0] n_l, m_l, acc, acc_next;
  logic [W:0]   sum;
  logic         phase, cen_next;

  assign chg = (n != n_l) || (m != m_l);

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, n_l};
    cen_next = 1'b0;
    acc_next = acc;
    if (m_l == '0) begin
      acc_next = '0;
    end else if (n_l >= m_l) begin
      // Rate saturates at one pulse per clock; keep acc clean instead of carrying the excess
      cen_next = 1'b1;
      acc_next = '0;
    end else if (sum >= {1'b0, m_l}) begin
      cen_next = 1'b1;
      acc_next = W'(sum - {1'b0, m_l});
    end else begin
      acc_next = sum[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_l   <= '0;
      m_l   <= '0;
      acc   <= '0;
      phase <= 1'b0;
      cen   <= 1'b0;
      cen2  <= 1'b0;
    end else if (chg) begin
      n_l   <= n;
      m_l   <= m;
      acc   <= '0;
      phase <= 1'b0;
      cen   <= 1'b0;
      cen2  <= 1'b0;
    end else if (run) begin
      acc   <= acc_next;
      cen   <= cen_next;
      cen2  <= cen_next & ~phase;
      phase <= phase ^ cen_next;
    end else begin
      cen   <= 1'b0;
      cen2  <= 1'b0;
    end
  end

endmodule

// File: rtl/jtframe_cen_multi.sv
// CH fractional clock-enable channels sharing one emulated PLL lock counter that
// restarts whenever any channel is reprogrammed.
module jtframe_cen_multi
  import jtframe_cen_pkg::*;
#(
  parameter int CH          = CH_DEF,
  parameter int W           = W_DEF,
  parameter int LOCK_CYCLES = LOCK_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH*W-1:0] n,
  input  logic [CH*W-1:0] m,
  output logic [CH-1:0]   cen,
  output logic [CH-1:0]   cen2,
  output logic            locked
);

  localparam int             CW        = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0]  LOCK_LAST = CW'(LOCK_CYCLES);

  logic [CW-1:0]      cnt;
  logic [CH-1:0]      chg;
  logic               chg_any, restart, run;
  logic [LANE_VW-1:0] n_pad, m_pad;

  assign n_pad   = LANE_VW'(n);
  assign m_pad   = LANE_VW'(m);
  assign chg_any = |chg;
  // A change while the counter is still at its start point (the first latch after
  // reset) is already covered by the count in progress, so it does not restart it.
  assign restart = chg_any && (locked || (cnt != '0));
  assign run     = locked && !chg_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      locked <= 1'b0;
    end else if (restart) begin
      cnt    <= '0;
      locked <= 1'b0;
    end else if (!locked) begin
      cnt <= cnt + CW'(1);
      if (cnt + CW'(1) == LOCK_LAST) locked <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [W-1:0] n_k, m_k;
      assign n_k = W'(lane(n_pad, gi, W));
      assign m_k = W'(lane(m_pad, gi, W));

      jtframe_cen_ch #(.W(W)) u_ch (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .n     (n_k),
        .m     (m_k),
        .chg   (chg[gi]),
        .cen   (cen[gi]),
        .cen2  (cen2[gi])
      );
    end
  endgenerate

endmodule
